// File: rtl/bft_leaf_endpoint.sv
// BFT-side endpoint for one leaf slot: buffers leaf packets toward the switch,
// requests retransmission on overflow, forwards switch packets and ap_start to the leaf.
module bft_leaf_endpoint #(
  parameter int PKT_W = 49,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_400,
  input  logic             reset_400,
  input  logic [PKT_W-1:0] dout_leaf_interface2bft,
  output logic             resend,
  output logic [PKT_W-1:0] din_leaf_bft2interface,
  output logic             ap_start,
  input  logic             start_set,
  input  logic             start_clr,
  input  logic [PKT_W-1:0] s_data,
  input  logic             s_valid,
  output logic [PKT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] tx_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             m_valid_q, m_valid_d;
  logic             resend_q, resend_d;
  logic             ap_start_q, ap_start_d;
  logic [PKT_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, drop_cnt_q, drop_cnt_d, tx_cnt_q, tx_cnt_d;

  logic leaf_vld, pop, accept, reject;

  // A full FIFO still accepts when the head is popped on the same edge.
  assign leaf_vld = dout_leaf_interface2bft[PKT_W-1];
  assign pop      = m_valid_q & m_ready;
  assign accept   = leaf_vld & ((count_q != FULL_CNT) | pop);
  assign reject   = leaf_vld & ~accept;

  always_comb begin
    wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    m_valid_d  = (count_d != '0);
    resend_d   = reject;
    tx_data_d  = s_valid ? s_data : '0;
    ap_start_d = start_clr ? 1'b0 : (start_set ? 1'b1 : ap_start_q);
    rx_cnt_d   = (accept  && rx_cnt_q   != '1) ? rx_cnt_q   + CNT_W'(1) : rx_cnt_q;
    drop_cnt_d = (reject  && drop_cnt_q != '1) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    tx_cnt_d   = (s_valid && tx_cnt_q   != '1) ? tx_cnt_q   + CNT_W'(1) : tx_cnt_q;
  end

  always_ff @(posedge clk_400) begin
    if (!reset_400) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      m_valid_q  <= 1'b0;
      resend_q   <= 1'b0;
      ap_start_q <= 1'b0;
      tx_data_q  <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
      tx_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      m_valid_q  <= m_valid_d;
      resend_q   <= resend_d;
      ap_start_q <= ap_start_d;
      tx_data_q  <= tx_data_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk_400) begin
    if (reset_400 && accept) mem_q[wr_ptr_q] <= dout_leaf_interface2bft;
  end

  assign m_data                 = mem_q[rd_ptr_q];
  assign m_valid                = m_valid_q;
  assign resend                 = resend_q;
  assign ap_start               = ap_start_q;
  assign din_leaf_bft2interface = tx_data_q;
  assign rx_cnt                 = rx_cnt_q;
  assign drop_cnt               = drop_cnt_q;
  assign tx_cnt                 = tx_cnt_q;

endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Directed bench for bft_leaf_endpoint; a second instance with 4-bit counters
// shares all inputs so counter saturation can be observed.
module tb_bft_leaf_endpoint;

  localparam int PKT_W = 49;

  logic             clk_400 = 1'b0;
  logic             reset_400;
  logic [PKT_W-1:0] leaf_w;
  logic             start_set, start_clr, s_valid, m_ready;
  logic [PKT_W-1:0] s_data;

  logic             resend, ap_start, m_valid;
  logic [PKT_W-1:0] din_leaf, m_data;
  logic [15:0]      rx_cnt, drop_cnt, tx_cnt;

  logic             resend4, ap_start4, m_valid4;
  logic [PKT_W-1:0] din_leaf4, m_data4;
  logic [3:0]       rx_cnt4, drop_cnt4, tx_cnt4;

  int n_chk = 0;
  int n_fail = 0;
  int exp_rx, exp_drop, exp_tx;
  logic [PKT_W-1:0] fill_w [17];
  logic [PKT_W-1:0] drain_exp [16];
  logic [PKT_W-1:0] extra_w;

  always #5 clk_400 = ~clk_400;

  bft_leaf_endpoint #(.PKT_W(PKT_W), .DEPTH(16), .CNT_W(16)) dut (
    .clk_400(clk_400), .reset_400(reset_400),
    .dout_leaf_interface2bft(leaf_w), .resend(resend),
    .din_leaf_bft2interface(din_leaf), .ap_start(ap_start),
    .start_set(start_set), .start_clr(start_clr),
    .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rx_cnt(rx_cnt), .drop_cnt(drop_cnt), .tx_cnt(tx_cnt)
  );

  bft_leaf_endpoint #(.PKT_W(PKT_W), .DEPTH(16), .CNT_W(4)) dut4 (
    .clk_400(clk_400), .reset_400(reset_400),
    .dout_leaf_interface2bft(leaf_w), .resend(resend4),
    .din_leaf_bft2interface(din_leaf4), .ap_start(ap_start4),
    .start_set(start_set), .start_clr(start_clr),
    .s_data(s_data), .s_valid(s_valid),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .rx_cnt(rx_cnt4), .drop_cnt(drop_cnt4), .tx_cnt(tx_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_400);
    #1;
  endtask

  initial begin
    reset_400 = 1'b0;
    leaf_w    = 49'h1_0000_0000_00F0;
    start_set = 1'b0; start_clr = 1'b0;
    s_valid   = 1'b0; s_data = '0;
    m_ready   = 1'b0;

    // reset with leaf traffic present
    repeat (3) tick();
    chk("rst_resend", resend, 0);
    chk("rst_ap_start", ap_start, 0);
    chk("rst_din", din_leaf, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rx", rx_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_tx", tx_cnt, 0);

    reset_400 = 1'b1;
    leaf_w = 49'h1_0000_0000_00A0;
    tick();
    chk("post_rst_m_valid", m_valid, 1);
    chk("post_rst_m_data", m_data, 49'h1_0000_0000_00A0);
    chk("post_rst_rx", rx_cnt, 1);
    exp_rx = 1;
    leaf_w = 49'h0_0000_0000_00EE;   // valid flag clear: ignored
    m_ready = 1'b1;
    tick();
    chk("drain_a0_m_valid", m_valid, 0);
    chk("invalid_word_rx", rx_cnt, exp_rx);

    // basic receive, streaming
    for (int i = 1; i <= 3; i++) begin
      leaf_w = 49'h1_0000_0000_00A0 + 49'(i);
      tick();
      exp_rx++;
      chk("basic_m_valid", m_valid, 1);
      chk("basic_m_data", m_data, 49'h1_0000_0000_00A0 + 49'(i));
      chk("basic_resend", resend, 0);
    end
    leaf_w = '0;
    tick();
    chk("basic_empty", m_valid, 0);
    chk("basic_rx", rx_cnt, exp_rx);

    // fill to DEPTH, 17th is rejected
    m_ready = 1'b0;
    exp_drop = 0;
    for (int i = 0; i < 17; i++) begin
      fill_w[i] = 49'h1_0000_0000_0B00 + 49'(i);
      leaf_w = fill_w[i];
      tick();
      chk("fill_resend", resend, (i == 16) ? 1 : 0);
    end
    exp_rx += 16;
    exp_drop = 1;
    leaf_w = '0;
    tick();
    chk("fill_resend_pulse_end", resend, 0);
    chk("fill_drop", drop_cnt, exp_drop);
    chk("fill_rx", rx_cnt, exp_rx);
    chk("fill_head", m_data, fill_w[0]);

    // full with simultaneous pop
    extra_w = 49'h1_0000_0000_0CCC;
    leaf_w = extra_w;
    m_ready = 1'b1;
    tick();
    exp_rx++;
    chk("simpop_resend", resend, 0);
    chk("simpop_drop", drop_cnt, exp_drop);
    chk("simpop_rx", rx_cnt, exp_rx);
    leaf_w = '0;
    for (int i = 0; i < 15; i++) drain_exp[i] = fill_w[i+1];
    drain_exp[15] = extra_w;
    for (int i = 0; i < 16; i++) begin
      chk("drain_m_valid", m_valid, 1);
      chk("drain_m_data", m_data, drain_exp[i]);
      tick();
    end
    chk("drain_empty", m_valid, 0);

    // m_ready while empty has no effect
    tick();
    chk("empty_ready_m_valid", m_valid, 0);

    // transmit path
    exp_tx = 0;
    s_valid = 1'b1; s_data = 49'h1_2345_6789_ABCD;
    tick();
    exp_tx++;
    chk("tx_din", din_leaf, 49'h1_2345_6789_ABCD);
    s_valid = 1'b0;
    tick();
    chk("tx_idle_din", din_leaf, 0);
    chk("tx_cnt1", tx_cnt, exp_tx);
    s_valid = 1'b1; s_data = 49'h0_0000_0000_0055;
    tick();
    exp_tx++;
    s_valid = 1'b0; s_data = '0;
    chk("tx_noflag_din", din_leaf, 49'h0_0000_0000_0055);
    chk("tx_cnt2", tx_cnt, exp_tx);

    // ap_start
    start_set = 1'b1;
    tick();
    chk("ap_set", ap_start, 1);
    start_set = 1'b0;
    tick();
    chk("ap_hold", ap_start, 1);
    start_set = 1'b1; start_clr = 1'b1;
    tick();
    chk("ap_clr_wins", ap_start, 0);
    start_set = 1'b0; start_clr = 1'b0;
    tick();
    chk("ap_stay_low", ap_start, 0);

    // saturation: fill, then 20 rejects
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      leaf_w = 49'h1_0000_0000_0D00 + 49'(i);
      tick();
    end
    exp_rx += 16;
    for (int i = 0; i < 20; i++) begin
      leaf_w = 49'h1_0000_0000_0E00 + 49'(i);
      tick();
      chk("sat_resend", resend, 1);
    end
    exp_drop += 20;
    chk("sat_drop16", drop_cnt, exp_drop);
    chk("sat_drop4", drop_cnt4, 15);
    chk("sat_rx4", rx_cnt4, 15);
    chk("sat_rx16", rx_cnt, exp_rx);
    chk("sat_head", m_data, 49'h1_0000_0000_0D00);

    // reset mid-operation discards everything without resend
    reset_400 = 1'b0;
    tick();
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_resend", resend, 0);
    reset_400 = 1'b1;
    leaf_w = '0;
    tick();
    chk("midrst_resend_after", resend, 0);
    chk("midrst_m_valid_after", m_valid, 0);
    chk("midrst_drop", drop_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bft_leaf_endpoint.md
Name: bft_leaf_endpoint

Overview:
Network-side (BFT) endpoint for one leaf port; the counterpart of a leaf interface.
- Receives 49-bit packets the leaf emits on dout_leaf_interface2bft, buffers them in a FIFO and presents them to the upstream switch as a valid/ready stream.
- Requests retransmission from the leaf via resend when a packet cannot be buffered.
- Forwards switch-originated packets to the leaf on din_leaf_bft2interface and drives the leaf's ap_start.
- Sits between a BFT leaf-level switch port and one leaf slot; single 400 MHz domain.

Parameters:
- PKT_W, 49, packet width; bit PKT_W-1 is the valid flag, bits PKT_W-2:0 are routing and payload (opaque here).
- DEPTH, 16, receive FIFO depth in words (power of 2, >=2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_400  in  1  sole clock.
- reset_400  in  1  synchronous, active-low reset.
- dout_leaf_interface2bft  in  PKT_W  packet from leaf; valid when bit PKT_W-1 = 1.
- resend  out  1  retransmit request to leaf.
- din_leaf_bft2interface  out  PKT_W  packet to leaf.
- ap_start  out  1  start level to leaf.
- start_set  in  1  pulse: set ap_start.
- start_clr  in  1  pulse: clear ap_start.
- s_data  in  PKT_W  switch-to-leaf packet.
- s_valid  in  1  s_data valid.
- m_data  out  PKT_W  leaf-to-switch packet (FIFO head).
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  switch accepts m_data.
- rx_cnt  out  CNT_W  leaf packets accepted.
- drop_cnt  out  CNT_W  leaf packets dropped (resend issued).
- tx_cnt  out  CNT_W  packets forwarded to leaf.

Behaviour:
Reset, sampled at a rising edge with reset_400 = 0:
- Outputs: resend = 0, ap_start = 0, din_leaf_bft2interface = 0, m_valid = 0, all counters = 0.
- FIFO pointers and count = 0; FIFO contents are don't-care.
- Reset mid-operation discards all buffered packets. No resend is generated for them.

Receive path:
- A leaf word with bit PKT_W-1 = 1 at edge t is accepted if count < DEPTH, or if count = DEPTH and m_valid & m_ready at t (simultaneous pop frees a slot).
- Accept: written at the tail; rx_cnt + 1.
- Reject: word discarded; resend = 1 for exactly the cycle after t (registered, one-cycle pulse per rejected word); drop_cnt + 1. Back-to-back rejects keep resend high for consecutive cycles.
- Words with bit PKT_W-1 = 0 are ignored: no write, no count change.

FIFO:
- First-word fall-through. m_data is the head word. m_valid = (count != 0), registered.
- Pop when m_valid & m_ready.
- Write latency: a word accepted at edge t is visible on m_data/m_valid after edge t (next cycle) when the FIFO was empty.
- Simultaneous push and pop: count unchanged.
- Pointers wrap modulo DEPTH.
- m_ready while empty: no effect.

Transmit path:
- din_leaf_bft2interface is registered. At each edge it loads s_data if s_valid, else 0.
- Latency is 1 cycle. There is no backpressure: the leaf always accepts.
- tx_cnt + 1 per s_valid cycle.
- s_valid with s_data bit PKT_W-1 = 0 is forwarded as given and still counted.

ap_start:
- Registered. start_set -> 1, start_clr -> 0.
- Both asserted in the same cycle: clear wins.

Counters:
- Saturate at 2^CNT_W - 1; never wrap.

Test Plan:
- Reset: drive reset_400 = 0 for 3 cycles with leaf traffic present -> resend = 0, ap_start = 0, din_leaf_bft2interface = 0, m_valid = 0, all counters 0; first valid word after release is accepted.
- Basic receive: 3 leaf words 0x1_0000_0000_00A1/A2/A3 on consecutive cycles, m_ready = 1 -> m_data shows A1, A2, A3 in order starting 1 cycle after each write; rx_cnt = 3; resend never asserted.
- Full and reject: m_ready = 0, 17 consecutive valid words (DEPTH = 16) -> 16 stored; 17th dropped; resend = 1 for one cycle after it; drop_cnt = 1. Then drain 16 words -> data in order, m_valid falls after the 16th pop.
- Full with simultaneous pop: FIFO full, valid word and m_ready = 1 in the same cycle -> word accepted, count stays 16, resend = 0, drop_cnt unchanged.
- Transmit and idle: s_valid = 1 with 0x1_2345_6789_ABCD, then s_valid = 0 -> din_leaf_bft2interface = 0x1_2345_6789_ABCD the next cycle, then 0; tx_cnt = 1.
- ap_start and saturation: start_set -> ap_start = 1 the next cycle; start_set and start_clr together -> 0. With CNT_W = 4, 20 rejected words -> drop_cnt holds at 15.
